control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port IR, input, 32 bits: current instruction; opcode is IR[31:27].
REQ-004 SHALL have port CON_FF, input, 1 bit: branch-condition flag from the datapath, valid in T5.
REQ-005 SHALL have port Stop, input, 1 bit: external halt request, sampled in T0.
REQ-006 SHALL have ports Gra, Grb, Grc, Rin, Rout, BAout, outputs, 1 bit each: register-select and register-file strobes.
REQ-007 SHALL have ports PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, outputs, 1 bit each: register load enables.
REQ-008 SHALL have ports PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, Inportout, outputs, 1 bit each: bus drive enables.
REQ-009 SHALL have ports Read, Write, IncPC, Outportin, outputs, 1 bit each: memory, PC-increment and output-port strobes.
REQ-010 SHALL have port opcode, output, 5 bits: ALU operation select.
REQ-011 SHALL have port Run, output, 1 bit: high while executing, low in HALT.

Function
REQ-012 SHALL implement a Moore FSM with states RST, T0-T7 and HALT; outputs depend only on the state and on IR/CON_FF as latched at T2.
REQ-013 SHALL transition RST->T0 on the first edge with clear low.
REQ-014 SHALL drive fetch as: T0 PCout+MARin+IncPC+Zin; T1 Zlowout+PCin+Read+MDRin; T2 MDRout+IRin.
REQ-015 SHALL latch IR[31:27] at the end of T2 and decode classes from it; encodings come from the shared package (ld=00000 ... halt=11011).
REQ-016 SHALL sequence R-type ALU ops (add/sub/and/or/shifts/rotates) as: T3 Grb+Rout+Yin; T4 Grc+Rout+opcode+Zin; T5 Zlowout+Gra+Rin; then T0.
REQ-017 SHALL sequence immediate ALU ops as in REQ-016, except T4 uses Cout in place of Grc+Rout.
REQ-018 SHALL sequence mul/div as: T3 Gra+Rout+Yin; T4 Grb+Rout+opcode+Zin; T5 Zlowout+LOin; T6 Zhighout+HIin; then T0.
REQ-019 SHALL sequence ld as: T3 Grb+BAout+Yin; T4 Cout+opcode=add+Zin; T5 Zlowout+MARin; T6 Read+MDRin; T7 MDRout+Gra+Rin; then T0.
REQ-020 SHALL sequence ldi as ld through T4, then T5 Zlowout+Gra+Rin, then T0.
REQ-021 SHALL sequence st as ld through T5, then T6 Gra+Rout+MDRin, T7 Write, then T0.
REQ-022 SHALL sequence br as: T3 Gra+Rout (CON_FF captured); T4 PCout+Yin; T5 Cout+add+Zin; T6 Zlowout+PCin only when CON_FF=1; then T0.
REQ-023 SHALL execute jr, jal, in, out, mfhi, mflo and neg/not each in at most three execute states (T3-T5).
REQ-024 SHALL make nop return T3->T0.
REQ-025 SHALL make halt enter HALT from T3, where Run=0, all strobes are 0, and the FSM stays until clear.
REQ-026 SHALL go T0->HALT, with no fetch strobes, when Stop=1 in T0; a mid-instruction Stop SHALL take effect only at the next T0.
REQ-027 SHALL treat an undefined opcode as nop.
REQ-028 SHALL never assert Read and Write together, nor more than one bus-out strobe in the same state.

Reset
REQ-029 SHALL, on clear=1 at a rising edge, enter RST from any state, including mid-instruction; no partial completion.
REQ-030 SHALL hold every strobe and opcode at 0 in RST, and Run at 0 in RST and 1 in T0-T7.

Configuration
REQ-031 SHALL, with macro CU_SINGLE_STEP_EN defined, add input Step and a PAUSE state entered from the last execute state; PAUSE->T0 only on a Step rising edge, with all strobes 0 and Run=1 in PAUSE.
REQ-032 SHALL, with CU_SINGLE_STEP_EN undefined, have no Step port and no PAUSE state.

Structure
REQ-033 SHALL place opcode encodings, state encodings and the ALU op constants in shared package cpu_pkg.
REQ-034 SHALL contain one sub-module, cu_decode: combinational opcode-to-instruction-class decoder.

Verification
REQ-035 SHALL verify: clear high 2 cycles, then low -> RST, T0; T0 shows PCout=MARin=IncPC=Zin=1, Run=1.
REQ-036 SHALL verify: IR=add (00011) -> T3-T5 strobes per REQ-016, opcode=00011 in T4, return to T0 on the 6th edge.
REQ-037 SHALL verify: br with CON_FF=0 -> no PCin in T6; with CON_FF=1 -> PCin=1 in T6.
REQ-038 SHALL verify: ld -> Read=1 in T1 and T6, Gra+Rin in T7, Write=0 throughout.
REQ-039 SHALL verify: clear asserted in T4 of mul -> RST next edge, HIin and LOin never asserted.
REQ-040 SHALL verify: halt opcode -> HALT after T3, Run=0, Stop/IR changes ignored until clear.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU op constants, control-unit states and instruction classes.
// Defining CU_SINGLE_STEP_EN adds the PAUSE state used by single-step mode.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU select used for address and branch-target arithmetic
  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    S_RST = 4'd0, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_LD, C_LDI, C_ST, C_ALU_R, C_ALU_I, C_MULDIV, C_NEGNOT,
    C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT
  } iclass_t;

  // Field order matches the output concatenation in control_unit
  typedef struct packed {
    logic gra, grb, grc, r_in, r_out, ba_out, pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic pc_out, mdr_out, zhigh_out, zlow_out, hi_out, lo_out, c_out, inport_out;
    logic read, write, inc_pc, outport_in;
  } ctrl_t;

  function automatic state_t last_state(iclass_t c);
    case (c)
      C_LD, C_ST:                return S_T7;
      C_MULDIV, C_BR:            return S_T6;
      C_ALU_R, C_ALU_I, C_LDI:   return S_T5;
      C_NEGNOT, C_JAL:           return S_T4;
      default:                   return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode-to-instruction-class decoder; undefined opcodes decode as nop.
module cu_decode
  import cpu_pkg::*;
(
  input  logic [4:0] op_i,
  output iclass_t    cls_o
);

  always_comb begin
    cls_o = C_NOP;
    case (op_i)
      OP_LD:                                  cls_o = C_LD;
      OP_LDI:                                 cls_o = C_LDI;
      OP_ST:                                  cls_o = C_ST;
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:          cls_o = C_ALU_R;
      OP_ADDI, OP_ANDI, OP_ORI:               cls_o = C_ALU_I;
      OP_MUL, OP_DIV:                         cls_o = C_MULDIV;
      OP_NEG, OP_NOT:                         cls_o = C_NEGNOT;
      OP_BR:                                  cls_o = C_BR;
      OP_JR:                                  cls_o = C_JR;
      OP_JAL:                                 cls_o = C_JAL;
      OP_IN:                                  cls_o = C_IN;
      OP_OUT:                                 cls_o = C_OUT;
      OP_MFHI:                                cls_o = C_MFHI;
      OP_MFLO:                                cls_o = C_MFLO;
      OP_HALT:                                cls_o = C_HALT;
      default:                                cls_o = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore control unit: fetch T0-T2, class-specific execute T3-T7, HALT. All outputs registered.
// Defining CU_SINGLE_STEP_EN adds a Step input and a PAUSE state after each instruction.
module control_unit
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
`ifdef CU_SINGLE_STEP_EN
  input  logic        Step,
`endif
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
  output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, Inportout,
  output logic        Read, Write, IncPC, Outportin,
  output logic [4:0]  opcode,
  output logic        Run
);

  state_t     state_q, state_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [4:0] op_q, dec_op, opc_q, opc_d;
  logic       run_q, run_d;
  iclass_t    cls;
  logic       unused_ir;

  assign unused_ir = ^IR[26:0];

  // During T2 the class is taken straight from IR so T3 strobes are ready on the T2->T3 edge
  assign dec_op = (state_q == S_T2) ? IR[31:27] : op_q;

  cu_decode u_decode (.op_i(dec_op), .cls_o(cls));

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  localparam state_t S_DONE = S_PAUSE;
`else
  localparam state_t S_DONE = S_T0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:  state_d = S_T0;
      S_T0:   state_d = Stop ? S_HALT : S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if (state_q == last_state(cls) || state_q == S_T7)
          state_d = (cls == C_HALT) ? S_HALT : S_DONE;
        else
          state_d = state_t'(state_q + 4'd1);
      end
      S_HALT: state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_PAUSE: if (Step && !step_q) state_d = S_T0;
`endif
      default: state_d = S_RST;
    endcase
    if (clear) state_d = S_RST;
  end

  // Strobes are a function of the state being entered, so they register alongside it
  always_comb begin
    ctrl_d = '0;
    opc_d  = '0;
    run_d  = !(state_d inside {S_RST, S_HALT});
    case (state_d)
      S_T0: begin ctrl_d.pc_out = 1'b1; ctrl_d.mar_in = 1'b1; ctrl_d.inc_pc = 1'b1; ctrl_d.z_in = 1'b1; end
      S_T1: begin ctrl_d.zlow_out = 1'b1; ctrl_d.pc_in = 1'b1; ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
      S_T2: begin ctrl_d.mdr_out = 1'b1; ctrl_d.ir_in = 1'b1; end
      S_T3: case (cls)
        C_LD, C_LDI, C_ST: begin ctrl_d.grb = 1'b1; ctrl_d.ba_out = 1'b1; ctrl_d.y_in = 1'b1; end
        C_ALU_R, C_ALU_I:  begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
        C_MULDIV:          begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.y_in = 1'b1; end
        C_BR:              begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; end
        C_NEGNOT: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = dec_op; end
        C_JR:     begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
        C_JAL:    begin ctrl_d.pc_out = 1'b1; ctrl_d.grb = 1'b1; ctrl_d.r_in = 1'b1; end
        C_IN:     begin ctrl_d.inport_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        C_OUT:    begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.outport_in = 1'b1; end
        C_MFHI:   begin ctrl_d.hi_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        C_MFLO:   begin ctrl_d.lo_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        default: ;
      endcase
      S_T4: case (cls)
        C_LD, C_LDI, C_ST: begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = ALU_ADD; end
        C_ALU_R:  begin ctrl_d.grc = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = dec_op; end
        C_ALU_I:  begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = dec_op; end
        C_MULDIV: begin ctrl_d.grb = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = dec_op; end
        C_BR:     begin ctrl_d.pc_out = 1'b1; ctrl_d.y_in = 1'b1; end
        C_NEGNOT: begin ctrl_d.zlow_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        C_JAL:    begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.pc_in = 1'b1; end
        default: ;
      endcase
      S_T5: case (cls)
        C_LD, C_ST:                begin ctrl_d.zlow_out = 1'b1; ctrl_d.mar_in = 1'b1; end
        C_LDI, C_ALU_R, C_ALU_I:   begin ctrl_d.zlow_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        C_MULDIV:                  begin ctrl_d.zlow_out = 1'b1; ctrl_d.lo_in = 1'b1; end
        C_BR:     begin ctrl_d.c_out = 1'b1; ctrl_d.z_in = 1'b1; opc_d = ALU_ADD; end
        default: ;
      endcase
      S_T6: case (cls)
        C_LD:     begin ctrl_d.read = 1'b1; ctrl_d.mdr_in = 1'b1; end
        C_ST:     begin ctrl_d.gra = 1'b1; ctrl_d.r_out = 1'b1; ctrl_d.mdr_in = 1'b1; end
        C_MULDIV: begin ctrl_d.zhigh_out = 1'b1; ctrl_d.hi_in = 1'b1; end
        // CON_FF is sampled on the T5->T6 edge, while the datapath holds it valid
        C_BR:     begin ctrl_d.zlow_out = CON_FF; ctrl_d.pc_in = CON_FF; end
        default: ;
      endcase
      S_T7: case (cls)
        C_LD: begin ctrl_d.mdr_out = 1'b1; ctrl_d.gra = 1'b1; ctrl_d.r_in = 1'b1; end
        C_ST: ctrl_d.write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
      opc_q   <= '0;
      run_q   <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      opc_q   <= opc_d;
      run_q   <= run_d;
      if (state_q == S_T2) op_q <= IR[31:27];
    end
`ifdef CU_SINGLE_STEP_EN
    step_q <= clear ? 1'b0 : Step;
`endif
  end

  assign {Gra, Grb, Grc, Rin, Rout, BAout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin,
          PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, Inportout,
          Read, Write, IncPC, Outportin} = ctrl_q;
  assign opcode = opc_q;
  assign Run    = run_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction strobe sequences from a table-driven model.
module tb_control_unit;

  logic        Clock = 1'b0, clear = 1'b1, CON_FF = 1'b0, Stop = 1'b0;
  logic [31:0] IR = '0;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, Inportout;
  logic Read, Write, IncPC, Outportin, Run;
  logic [4:0] opcode;

  control_unit dut (
    .Clock(Clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout),
    .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout), .Cout(Cout), .Inportout(Inportout),
    .Read(Read), .Write(Write), .IncPC(IncPC), .Outportin(Outportin),
    .opcode(opcode), .Run(Run)
  );

  always #5 Clock = ~Clock;

  localparam int GRA = 0, GRB = 1, GRC = 2, RIN = 3, ROUT = 4, BAOUT = 5, PCIN = 6, IRIN = 7;
  localparam int MARIN = 8, MDRIN = 9, YIN = 10, ZIN = 11, HIIN = 12, LOIN = 13, PCOUT = 14;
  localparam int MDROUT = 15, ZHI = 16, ZLO = 17, HIOUT = 18, LOOUT = 19, COUT = 20;
  localparam int INPOUT = 21, READ = 22, WRITE = 23, INCPC = 24, OUTPIN = 25;
  localparam logic [4:0] ADD = 5'd3, MUL = 5'd16, HALT = 5'd27;

  function automatic logic [31:0] b(input int i);
    return 32'd1 << i;
  endfunction

  localparam logic [31:0] BUS = (32'd1 << ROUT) | (32'd1 << BAOUT) | (32'd1 << PCOUT) |
    (32'd1 << MDROUT) | (32'd1 << ZHI) | (32'd1 << ZLO) | (32'd1 << HIOUT) |
    (32'd1 << LOOUT) | (32'd1 << COUT) | (32'd1 << INPOUT);

  logic [31:0] obs;
  always_comb begin
    obs = '0;
    obs[GRA] = Gra;  obs[GRB] = Grb;  obs[GRC] = Grc;  obs[RIN] = Rin;  obs[ROUT] = Rout;
    obs[BAOUT] = BAout; obs[PCIN] = PCin; obs[IRIN] = IRin; obs[MARIN] = MARin;
    obs[MDRIN] = MDRin; obs[YIN] = Yin; obs[ZIN] = Zin; obs[HIIN] = HIin; obs[LOIN] = LOin;
    obs[PCOUT] = PCout; obs[MDROUT] = MDRout; obs[ZHI] = Zhighout; obs[ZLO] = Zlowout;
    obs[HIOUT] = HIout; obs[LOOUT] = LOout; obs[COUT] = Cout; obs[INPOUT] = Inportout;
    obs[READ] = Read; obs[WRITE] = Write; obs[INCPC] = IncPC; obs[OUTPIN] = Outportin;
  end

  typedef struct packed { logic [31:0] m; logic [4:0] op; } step_t;
  step_t exp_q[$];
  int n_chk = 0, n_fail = 0;

  logic [31:0] F0, F1, F2;
  initial begin
    F0 = b(PCOUT) | b(MARIN) | b(INCPC) | b(ZIN);
    F1 = b(ZLO) | b(PCIN) | b(READ) | b(MDRIN);
    F2 = b(MDROUT) | b(IRIN);
  end

  task automatic push(input logic [31:0] m, input logic [4:0] o);
    exp_q.push_back('{m, o});
  endtask

  // Expected strobes for every state of one instruction, T0 through its last execute state
  task automatic build(input logic [4:0] op, input logic con);
    logic [31:0] wb;
    wb = b(GRA) | b(RIN);
    exp_q.delete();
    push(F0, 5'd0); push(F1, 5'd0); push(F2, 5'd0);
    if (op <= 5'd2) begin
      push(b(GRB) | b(BAOUT) | b(YIN), 5'd0);
      push(b(COUT) | b(ZIN), ADD);
      if (op == 5'd1) push(b(ZLO) | wb, 5'd0);
      else begin
        push(b(ZLO) | b(MARIN), 5'd0);
        if (op == 5'd0) begin push(b(READ) | b(MDRIN), 5'd0); push(b(MDROUT) | wb, 5'd0); end
        else begin push(b(GRA) | b(ROUT) | b(MDRIN), 5'd0); push(b(WRITE), 5'd0); end
      end
    end else if (op <= 5'd14) begin
      push(b(GRB) | b(ROUT) | b(YIN), 5'd0);
      push(((op <= 5'd11) ? (b(GRC) | b(ROUT)) : b(COUT)) | b(ZIN), op);
      push(b(ZLO) | wb, 5'd0);
    end else if (op <= 5'd16) begin
      push(b(GRA) | b(ROUT) | b(YIN), 5'd0);
      push(b(GRB) | b(ROUT) | b(ZIN), op);
      push(b(ZLO) | b(LOIN), 5'd0);
      push(b(ZHI) | b(HIIN), 5'd0);
    end else if (op <= 5'd18) begin
      push(b(GRB) | b(ROUT) | b(ZIN), op);
      push(b(ZLO) | wb, 5'd0);
    end else begin
      case (op)
        5'd19: begin
          push(b(GRA) | b(ROUT), 5'd0);
          push(b(PCOUT) | b(YIN), 5'd0);
          push(b(COUT) | b(ZIN), ADD);
          push(con ? (b(ZLO) | b(PCIN)) : 32'd0, 5'd0);
        end
        5'd20: push(b(GRA) | b(ROUT) | b(PCIN), 5'd0);
        5'd21: begin push(b(PCOUT) | b(GRB) | b(RIN), 5'd0); push(b(GRA) | b(ROUT) | b(PCIN), 5'd0); end
        5'd22: push(b(INPOUT) | wb, 5'd0);
        5'd23: push(b(GRA) | b(ROUT) | b(OUTPIN), 5'd0);
        5'd24: push(b(HIOUT) | wb, 5'd0);
        5'd25: push(b(LOOUT) | wb, 5'd0);
        default: push(32'd0, 5'd0);
      endcase
    end
  endtask

  task automatic load_ir(input logic [4:0] op, input logic con);
    logic [31:0] r;
    r = $urandom();
    IR = {op, r[26:0]};
    CON_FF = con;
    build(op, con);
  endtask

  task automatic test_reset();
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      n_chk++;
      if (obs !== 32'd0 || opcode !== 5'd0 || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_rst: strobes=%h opcode=%0d Run=%b, want 0/0/0", obs, opcode, Run);
      end
    end
    clear = 1'b0;
    @(negedge Clock);
    n_chk++;
    if (obs !== F0 || opcode !== 5'd0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_t0: strobes=%h opcode=%0d Run=%b, want %h/0/1", obs, opcode, Run, F0);
    end
  endtask

  task automatic test_directed();
    logic [4:0] ops [15];
    logic       cons [15];
    ops  = '{5'd3, 5'd19, 5'd19, 5'd0, 5'd2, 5'd1, 5'd16, 5'd15, 5'd17, 5'd21, 5'd22, 5'd23, 5'd24, 5'd26, 5'd30};
    cons = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 15; k++) begin
      load_ir(ops[k], cons[k]);
      foreach (exp_q[j]) begin
        n_chk++;
        if (obs !== exp_q[j].m || opcode !== exp_q[j].op || Run !== 1'b1) begin
          n_fail++;
          $display("FAIL directed op=%0d con=%b T%0d: strobes=%h opcode=%0d Run=%b, want %h/%0d/1",
                   ops[k], cons[k], j, obs, opcode, Run, exp_q[j].m, exp_q[j].op);
        end
        n_chk++;
        if ((Read && Write) || $countones(obs & BUS) > 1) begin
          n_fail++;
          $display("FAIL directed_exclusive op=%0d T%0d: strobes=%h", ops[k], j, obs);
        end
        @(negedge Clock);
      end
    end
    n_chk++;
    if (obs !== F0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL directed_return_t0: strobes=%h Run=%b, want %h/1", obs, Run, F0);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic       con;
    for (int k = 0; k < 40; k++) begin
      op  = 5'($urandom_range(0, 31));
      if (op == HALT) op = 5'd26;
      con = 1'($urandom_range(0, 1));
      load_ir(op, con);
      foreach (exp_q[j]) begin
        n_chk++;
        if (obs !== exp_q[j].m || opcode !== exp_q[j].op || Run !== 1'b1) begin
          n_fail++;
          $display("FAIL random op=%0d con=%b T%0d: strobes=%h opcode=%0d Run=%b, want %h/%0d/1",
                   op, con, j, obs, opcode, Run, exp_q[j].m, exp_q[j].op);
        end
        @(negedge Clock);
      end
    end
  endtask

  task automatic test_stop();
    load_ir(ADD, 1'b0);
    foreach (exp_q[j]) begin
      if (j == 3) Stop = 1'b1;
      n_chk++;
      if (obs !== exp_q[j].m || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL stop_mid T%0d: strobes=%h Run=%b, want %h/1", j, obs, Run, exp_q[j].m);
      end
      @(negedge Clock);
    end
    n_chk++;
    if (obs !== F0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_next_t0: strobes=%h Run=%b, want %h/1", obs, Run, F0);
    end
    @(negedge Clock);
    Stop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs !== 32'd0 || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL stop_halt cycle%0d: strobes=%h Run=%b, want 0/0", i, obs, Run);
      end
      @(negedge Clock);
    end
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);
    n_chk++;
    if (obs !== F0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_recover: strobes=%h Run=%b, want %h/1", obs, Run, F0);
    end
  endtask

  task automatic test_clear_mid_mul();
    logic hilo_seen;
    hilo_seen = 1'b0;
    load_ir(MUL, 1'b0);
    for (int j = 0; j < 5; j++) begin
      hilo_seen = hilo_seen | HIin | LOin;
      n_chk++;
      if (obs !== exp_q[j].m || opcode !== exp_q[j].op) begin
        n_fail++;
        $display("FAIL mul_pre_clear T%0d: strobes=%h opcode=%0d, want %h/%0d", j, obs, opcode, exp_q[j].m, exp_q[j].op);
      end
      if (j == 4) clear = 1'b1;
      @(negedge Clock);
    end
    clear = 1'b0;
    hilo_seen = hilo_seen | HIin | LOin;
    n_chk++;
    if (obs !== 32'd0 || opcode !== 5'd0 || Run !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_clear_rst: strobes=%h opcode=%0d Run=%b, want 0/0/0", obs, opcode, Run);
    end
    @(negedge Clock);
    hilo_seen = hilo_seen | HIin | LOin;
    n_chk++;
    if (obs !== F0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_clear_t0: strobes=%h Run=%b, want %h/1", obs, Run, F0);
    end
    n_chk++;
    if (hilo_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_clear_hilo: HIin/LOin seen=%b, want 0", hilo_seen);
    end
  endtask

  task automatic test_halt();
    logic [31:0] r;
    load_ir(HALT, 1'b0);
    foreach (exp_q[j]) begin
      n_chk++;
      if (obs !== exp_q[j].m || Run !== 1'b1) begin
        n_fail++;
        $display("FAIL halt_seq T%0d: strobes=%h Run=%b, want %h/1", j, obs, Run, exp_q[j].m);
      end
      @(negedge Clock);
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs !== 32'd0 || opcode !== 5'd0 || Run !== 1'b0) begin
        n_fail++;
        $display("FAIL halt_hold cycle%0d: strobes=%h opcode=%0d Run=%b, want 0/0/0", i, obs, opcode, Run);
      end
      r = $urandom();
      IR = r;
      Stop = r[0];
      @(negedge Clock);
    end
    Stop = 1'b0;
    clear = 1'b1;
    @(negedge Clock);
    clear = 1'b0;
    @(negedge Clock);
    n_chk++;
    if (obs !== F0 || Run !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_recover: strobes=%h Run=%b, want %h/1", obs, Run, F0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stop();
    test_clear_mid_mul();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
